// File: rtl/arbitro_compuertas_pkg.sv
// Shared definitions for the gate arbiter: function codes, FSM encoding and round-robin pick.
package paq_compuertas;

  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_NOR  = 3'b101;
  localparam logic [2:0] SEL_XNOR = 3'b110;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CAPTURA  = 2'd1,
    EJECUTA  = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

  // Returns {found, index} of the first set request at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_siguiente(input logic [7:0] req, input logic [2:0] ptr,
                                               input int n);
    logic [3:0] r;
    int j;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && req[j[2:0]]) r = {1'b1, j[2:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/arbitro_compuertas_unidad_logica.sv
// Combinational bitwise 3-input logic unit; codes 000 and 111 yield all zeros.
module unidad_logica
  import paq_compuertas::*;
#(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [ANCHO-1:0] c,
  input  logic [2:0]       sel,
  output logic [ANCHO-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_AND:  y = a & b & c;
      SEL_OR:   y = a | b | c;
      SEL_XOR:  y = a ^ b ^ c;
      SEL_NAND: y = ~(a & b & c);
      SEL_NOR:  y = ~(a | b | c);
      SEL_XNOR: y = ~(a ^ b ^ c);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/arbitro_compuertas.sv
// Round-robin arbiter sharing one logic unit; gnt 1 cycle after req, result held until sal_ack.
// Optional err output under ARB_COMP_ERR_EN flags invalid function codes.
module arbitro_compuertas
  import paq_compuertas::*;
#(
  parameter int N_REQ = 4,
  parameter int ANCHO = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       act,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ANCHO-1:0]     ent1,
  input  logic [N_REQ*ANCHO-1:0]     ent2,
  input  logic [N_REQ*ANCHO-1:0]     ent3,
  input  logic [N_REQ*3-1:0]         sel,
  output logic [N_REQ-1:0]           gnt,
  output logic [ANCHO-1:0]           sal,
  output logic                       sal_valida,
  output logic [$clog2(N_REQ)-1:0]   sal_id,
  input  logic                       sal_ack,
  output logic                       ocupado
`ifdef ARB_COMP_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int IDW = $clog2(N_REQ);

  estado_t          estado;
  logic [2:0]       ptr;
  logic [ANCHO-1:0] a_q, b_q, c_q;
  logic [2:0]       sel_q;
  logic [7:0]       req_ext;
  logic [3:0]       pick;
  logic             hay;
  logic [2:0]       idx;
  logic [ANCHO-1:0] y;

  unidad_logica #(.ANCHO(ANCHO)) u_logica (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .sel (sel_q),
    .y   (y)
  );

  // Pick is evaluated live in CAPTURA so a withdrawn request yields no grant.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_siguiente(req_ext, ptr, N_REQ);
    hay                  = pick[3];
    idx                  = pick[2:0];
    gnt                  = '0;
    if (estado == CAPTURA && hay) gnt = N_REQ'(1) << idx;
  end

  assign ocupado = (estado != INACTIVO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado     <= INACTIVO;
      ptr        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      sel_q      <= '0;
      sal        <= '0;
      sal_valida <= 1'b0;
      sal_id     <= '0;
`ifdef ARB_COMP_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      case (estado)
        INACTIVO: if (act && |req) estado <= CAPTURA;
        CAPTURA: begin
          if (hay) begin
            a_q    <= ent1[idx*ANCHO +: ANCHO];
            b_q    <= ent2[idx*ANCHO +: ANCHO];
            c_q    <= ent3[idx*ANCHO +: ANCHO];
            sel_q  <= sel[idx*3 +: 3];
            sal_id <= idx[IDW-1:0];
            ptr    <= (idx == 3'(N_REQ-1)) ? 3'd0 : idx + 3'd1;
            estado <= EJECUTA;
          end else begin
            estado <= INACTIVO;
          end
        end
        EJECUTA: begin
          sal        <= y;
          sal_valida <= 1'b1;
`ifdef ARB_COMP_ERR_EN
          err        <= (sel_q == 3'b000) || (sel_q == 3'b111);
`endif
          estado     <= ENTREGA;
        end
        ENTREGA: begin
          if (sal_ack) begin
            sal_valida <= 1'b0;
`ifdef ARB_COMP_ERR_EN
            err        <= 1'b0;
`endif
            estado     <= INACTIVO;
          end
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_compuertas.sv
// Scoreboard bench for arbitro_compuertas (N_REQ=4, ANCHO=8).
module tb_arbitro_compuertas;

  logic        clk = 1'b0;
  logic        rst;
  logic        act;
  logic [3:0]  req;
  logic [31:0] ent1, ent2, ent3;
  logic [11:0] sel;
  logic [3:0]  gnt;
  logic [7:0]  sal;
  logic        sal_valida;
  logic [1:0]  sal_id;
  logic        sal_ack;
  logic        ocupado;
`ifdef ARB_COMP_ERR_EN
  logic        err;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] sal;
    logic       err;
  } esp_t;

  esp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;

  arbitro_compuertas #(.N_REQ(4), .ANCHO(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .act        (act),
    .req        (req),
    .ent1       (ent1),
    .ent2       (ent2),
    .ent3       (ent3),
    .sel        (sel),
    .gnt        (gnt),
    .sal        (sal),
    .sal_valida (sal_valida),
    .sal_id     (sal_id),
    .sal_ack    (sal_ack),
`ifdef ARB_COMP_ERR_EN
    .err        (err),
`endif
    .ocupado    (ocupado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] modelo(input logic [2:0] s, input logic [7:0] a, b, c);
    case (s)
      3'd1:    return a & b & c;
      3'd2:    return a | b | c;
      3'd3:    return a ^ b ^ c;
      3'd4:    return ~(a & b & c);
      3'd5:    return ~(a | b | c);
      3'd6:    return ~(a ^ b ^ c);
      default: return 8'h00;
    endcase
  endfunction

  // Pop one expectation on every rising edge of sal_valida.
  always @(negedge clk) begin
    esp_t e;
    if (sal_valida && !prev_vld) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_sal", 32'(sal), 32'(e.sal));
        check("sb_id", 32'(sal_id), 32'(e.id));
`ifdef ARB_COMP_ERR_EN
        check("sb_err", 32'(err), 32'(e.err));
`endif
      end
    end
    prev_vld = sal_valida;
  end

  task automatic cargar(input int idx, input logic [7:0] e1, e2, e3, input logic [2:0] s);
    ent1[idx*8 +: 8] = e1;
    ent2[idx*8 +: 8] = e2;
    ent3[idx*8 +: 8] = e3;
    sel[idx*3 +: 3]  = s;
  endtask

  task automatic esperar_gnt(input int idx, input string tag);
    int n = 0;
    @(negedge clk);
    while (gnt[idx] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(gnt), 32'(1 << idx));
  endtask

  task automatic esperar_libre(input string tag);
    int n = 0;
    @(negedge clk);
    while (ocupado !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ocupado), 32'd0);
  endtask

  task automatic operar(input int idx, input logic [7:0] e1, e2, e3, input logic [2:0] s,
                        input logic [7:0] es, input logic ee, input string tag);
    @(posedge clk); #1;
    cargar(idx, e1, e2, e3, s);
    sb.push_back('{id: 2'(idx), sal: es, err: ee});
    req[idx] = 1'b1;
    esperar_gnt(idx, tag);
    @(posedge clk); #1;
    req[idx] = 1'b0;
    esperar_libre(tag);
  endtask

  initial begin
    logic [7:0] tabla[6];
    logic [7:0] exp1;
    int orden[5];
    int got, cyc, last, cnt, n;

    tabla = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69};
    orden = '{0, 1, 2, 3, 0};
    rst = 1'b1; act = 1'b1; sal_ack = 1'b1; req = '0;
    ent1 = '0; ent2 = '0; ent3 = '0; sel = '0;

    // Reset state
    #1;
    check("rst_sal", 32'(sal), 32'd0);
    check("rst_vld", 32'(sal_valida), 32'd0);
    check("rst_id", 32'(sal_id), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request with exact latency
    @(posedge clk); #1;
    cargar(0, 8'hFF, 8'h0F, 8'h3C, 3'b001);
    sb.push_back('{id: 2'd0, sal: 8'h0C, err: 1'b0});
    req = 4'b0001;
    @(negedge clk); check("t1_gnt_idle", 32'(gnt), 32'd0);
    @(negedge clk); check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_ocupado", 32'(ocupado), 32'd1);
    @(posedge clk); #1; req = '0;
    @(negedge clk); check("t1_vld_ejecuta", 32'(sal_valida), 32'd0);
    check("t1_gnt_pulse", 32'(gnt), 32'd0);
    @(negedge clk); check("t1_vld", 32'(sal_valida), 32'd1);
    check("t1_sal", 32'(sal), 32'h0C);
    @(negedge clk); check("t1_vld_drop", 32'(sal_valida), 32'd0);
    check("t1_libre", 32'(ocupado), 32'd0);

    // Round robin with all requests held (pointer reset first)
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++)
      cargar(i, 8'hC3 ^ 8'(i * 37), 8'h35 + 8'(i), 8'hF0 >> i, 3'(i + 1));
    for (int k = 0; k < 5; k++)
      sb.push_back('{id: 2'(orden[k]),
                     sal: modelo(3'(orden[k] + 1), 8'hC3 ^ 8'(orden[k] * 37),
                                 8'h35 + 8'(orden[k]), 8'hF0 >> orden[k]),
                     err: 1'b0});
    req = 4'b1111;
    got = 0; cyc = 0; last = 0;
    while (got < 5 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (gnt != 4'b0000) begin
        check("rr_gnt", 32'(gnt), 32'(1 << orden[got]));
        if (got > 0) check("rr_gap", 32'(cyc - last), 32'd4);
        last = cyc;
        got++;
        if (got == 5) begin
          @(posedge clk); #1; req = '0;
        end
      end
    end
    check("rr_count", 32'(got), 32'd5);
    esperar_libre("rr_libre");

    // Backpressure: requester 1 delivered, requester 2 waits
    @(posedge clk); #1;
    sal_ack = 1'b0;
    cargar(1, 8'h5A, 8'h3C, 8'h0F, 3'b011);
    cargar(2, 8'h12, 8'h34, 8'h56, 3'b010);
    exp1 = modelo(3'b011, 8'h5A, 8'h3C, 8'h0F);
    sb.push_back('{id: 2'd1, sal: exp1, err: 1'b0});
    sb.push_back('{id: 2'd2, sal: modelo(3'b010, 8'h12, 8'h34, 8'h56), err: 1'b0});
    req = 4'b0110;
    esperar_gnt(1, "bp_gnt1");
    @(posedge clk); #1; req[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (sal_valida !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      check("bp_vld", 32'(sal_valida), 32'd1);
      check("bp_sal", 32'(sal), 32'(exp1));
      check("bp_id", 32'(sal_id), 32'd1);
      check("bp_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; sal_ack = 1'b1;
    esperar_gnt(2, "bp_gnt2");
    @(posedge clk); #1; req[2] = 1'b0;
    esperar_libre("bp_libre");

    // Function sweep on requester 2
    for (int s = 1; s <= 6; s++)
      operar(2, 8'hAA, 8'hCC, 8'hF0, 3'(s), tabla[s-1], 1'b0, "sweep");
    operar(2, 8'hAA, 8'hCC, 8'hF0, 3'b000, 8'h00, 1'b1, "sweep_000");
    operar(2, 8'hAA, 8'hCC, 8'hF0, 3'b111, 8'h00, 1'b1, "sweep_111");

    // act dropped after grant: result still delivered, no new grant
    @(posedge clk); #1;
    cargar(0, 8'h0F, 8'hF0, 8'h3C, 3'b010);
    sb.push_back('{id: 2'd0, sal: 8'hFF, err: 1'b0});
    req = 4'b0001;
    esperar_gnt(0, "act_gnt");
    @(posedge clk); #1; act = 1'b0;
    esperar_libre("act_libre");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt != 4'b0000 || ocupado) cnt++;
    end
    check("act0_quiet", 32'(cnt), 32'd0);
    check("act0_sb_drained", 32'(sb.size()), 32'd0);
    sb.push_back('{id: 2'd0, sal: 8'hFF, err: 1'b0});
    @(posedge clk); #1; act = 1'b1;
    esperar_gnt(0, "act1_gnt");
    @(posedge clk); #1; req = '0;
    esperar_libre("act1_libre");

    // Reset pulse while in EJECUTA aborts the operation
    @(posedge clk); #1;
    cargar(1, 8'hFF, 8'hFF, 8'hFF, 3'b010);
    req = 4'b0010;
    esperar_gnt(1, "rst_gnt");
    @(posedge clk); #1;
    req = '0;
    rst = 1'b1;
    #1;
    check("rst_mid_sal", 32'(sal), 32'd0);
    check("rst_mid_vld", 32'(sal_valida), 32'd0);
    check("rst_mid_id", 32'(sal_id), 32'd0);
    check("rst_mid_ocupado", 32'(ocupado), 32'd0);
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sal_valida) cnt++;
    end
    check("rst_no_result", 32'(cnt), 32'd0);
    operar(3, 8'h81, 8'h18, 8'hFF, 3'b011, 8'h66, 1'b0, "post_rst_gnt3");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
